// File: rtl/processador_pkg.sv
// Shared encodings for the 8-bit processor control path.
// This includes FSM state codes, opcode/funct fields, ALU operand selects
// and the packed strobe bundle that the sequencer drives each cycle.
package processador_pkg;

   // Sequencer states. Plain constants keep the 3-bit debug encoding explicit.
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;
   localparam logic [2:0] S_ERROR  = 3'd7;

   // Major opcode classes (IR[7:6]).
   localparam logic [1:0] OP_R   = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_J   = 2'b11;

   // Function codes (IR[5:3]) that change sequencing.
   localparam logic [2:0] F_LW   = 3'b000;
   localparam logic [2:0] F_SW   = 3'b001;
   localparam logic [2:0] F_HALT = 3'b111;

   // ALU first operand select.
   localparam logic SRC1_PC    = 1'b0;
   localparam logic SRC1_REG_A = 1'b1;

   // ALU second operand select.
   typedef enum logic [1:0] {
      SRC2_REG_B  = 2'b00,
      SRC2_ONE    = 2'b01,
      SRC2_IMM    = 2'b10,
      SRC2_BR_OFF = 2'b11
   } alu_src2_e;

   // ALU operation select.
   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10,
      ALU_IMM   = 2'b11
   } alu_op_e;

   // One cycle's worth of datapath strobes.
   typedef struct packed {
      logic      pc_write;
      logic      ir_write;
      logic      reg_write;
      logic      mem_read;
      logic      mem_write;
      logic      mem_to_reg;
      logic      alu_src1;
      alu_src2_e alu_src2;
      alu_op_e   alu_op;
      logic      jump;
   } ctrl_t;

   function automatic logic is_load(input logic [1:0] op, input logic [2:0] fn);
      return (op == OP_MEM) && (fn == F_LW);
   endfunction

   function automatic logic is_store(input logic [1:0] op, input logic [2:0] fn);
      return (op == OP_MEM) && (fn == F_SW);
   endfunction

endpackage

// File: rtl/unidade_controle_multiciclo_if.sv
// Bundle between the multicycle sequencer and the datapath/memory port.
// The sequencer uses the master view; the datapath uses the slave view.
interface unidade_controle_multiciclo_if #(
   parameter int CNT_W = 16
);
   // Instruction fields and status coming from the datapath / memory
   logic [1:0]       opcode;
   logic [2:0]       funct;
   logic             zero;
   logic             mem_ready;
   // Strobes and status going to the datapath / memory
   logic             pc_write;
   logic             ir_write;
   logic             reg_write;
   logic             mem_read;
   logic             mem_write;
   logic             mem_to_reg;
   logic             alu_src1;
   logic [1:0]       alu_src2;
   logic [1:0]       alu_op;
   logic             jump;
   logic [2:0]       state;
   logic             halted;
   logic             error;
   logic [CNT_W-1:0] instr_count;

   modport master (
      input  opcode, funct, zero, mem_ready,
      output pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg,
             alu_src1, alu_src2, alu_op, jump, state, halted, error, instr_count
   );

   modport slave (
      output opcode, funct, zero, mem_ready,
      input  pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg,
             alu_src1, alu_src2, alu_op, jump, state, halted, error, instr_count
   );
endinterface

// File: rtl/unidade_controle_multiciclo_mem_wait_timer.sv
// Counts consecutive cycles spent waiting on the shared memory port.
// timeout flags the waiting cycle whose increment would reach MEM_TIMEOUT,
// so the sequencer can leave for ERROR on that same edge.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic inc,
   output logic timeout
);

   localparam logic [3:0] LAST_WAIT = 4'(MEM_TIMEOUT - 1);

   logic [3:0] count_q;
   logic [3:0] count_d;

   // Next count: clear wins, otherwise count waits without wrapping.
   always_comb begin
      // NOTE: assign a default first so every path writes count_d; otherwise a latch is inferred.
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (inc && (count_q != 4'hF)) begin
         count_d = count_q + 4'd1;
      end
   end

   assign timeout = inc && !clear && (count_q == LAST_WAIT);

   // Wait counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control sequencer for the 8-bit processor.
// Each instruction moves through FETCH, DECODE, EXEC, MEM and WB, and one
// strobe set is issued per cycle. Memory accesses wait on mem_ready and are
// bounded by a timeout that parks the FSM in ERROR until reset.
module unidade_controle_multiciclo
   import processador_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input logic                         clk,
   input logic                         rst_n,
   unidade_controle_multiciclo_if.master bus
);

   logic [2:0]       state_q;
   logic [2:0]       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             retire;
   ctrl_t            ctrl;

   logic             wait_active;
   logic             wait_clear;
   logic             wait_inc;
   logic             wait_timeout;

   logic             op_load;
   logic             op_store;
   logic             op_jump;
   logic             op_halt;

   assign op_load  = is_load(bus.opcode, bus.funct);
   assign op_store = is_store(bus.opcode, bus.funct);
   assign op_jump  = (bus.opcode == OP_J) && (bus.funct != F_HALT);
   assign op_halt  = (bus.opcode == OP_J) && (bus.funct == F_HALT);

   // The counter only runs in the two memory-waiting states. Being anywhere
   // else holds it at zero, which gives a clean start on entry to FETCH/MEM.
   assign wait_active = (state_q == S_FETCH) || (state_q == S_MEM);
   assign wait_clear  = !wait_active || bus.mem_ready;
   assign wait_inc    = wait_active && !bus.mem_ready;

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (wait_clear),
      .inc     (wait_inc),
      .timeout (wait_timeout)
   );

   // Next-state selection and retire detection.
   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            // A completing access beats a timeout landing on the same cycle.
            if (bus.mem_ready) begin
               state_d = S_DECODE;
            end else if (wait_timeout) begin
               state_d = S_ERROR;
            end
         end
         S_DECODE: begin
            if (op_halt) begin
               state_d = S_HALT;
               retire  = 1'b1;
            end else if (op_jump) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (bus.opcode)
               OP_R:    state_d = S_WB;
               OP_MEM:  state_d = (op_load || op_store) ? S_MEM : S_WB;
               default: begin
                  // Branches finish here; jumps never reach EXEC.
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end
            endcase
         end
         S_MEM: begin
            if (bus.mem_ready) begin
               if (op_store) begin
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end else begin
                  state_d = S_WB;
               end
            end else if (wait_timeout) begin
               state_d = S_ERROR;
            end
         end
         S_WB: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         default: begin
            // HALT and ERROR are sticky until reset.
            state_d = state_q;
         end
      endcase
   end

   // Per-state strobe decode; memory and branch outcomes also depend on inputs.
   always_comb begin
      ctrl = '0;
      case (state_q)
         S_FETCH: begin
            ctrl.mem_read = 1'b1;
            ctrl.alu_src1 = SRC1_PC;
            ctrl.alu_src2 = SRC2_ONE;
            ctrl.alu_op   = ALU_ADD;
            ctrl.ir_write = bus.mem_ready;
            ctrl.pc_write = bus.mem_ready;
         end
         S_DECODE: begin
            ctrl.jump     = op_jump;
            ctrl.pc_write = op_jump;
         end
         S_EXEC: begin
            ctrl.alu_src1 = SRC1_REG_A;
            case (bus.opcode)
               OP_R: begin
                  ctrl.alu_src2 = SRC2_REG_B;
                  ctrl.alu_op   = ALU_FUNCT;
               end
               OP_MEM: begin
                  ctrl.alu_src2 = SRC2_IMM;
                  ctrl.alu_op   = (op_load || op_store) ? ALU_ADD : ALU_IMM;
               end
               default: begin
                  // funct[0] selects beq (0) or bne (1).
                  ctrl.alu_src2 = SRC2_REG_B;
                  ctrl.alu_op   = ALU_SUB;
                  ctrl.pc_write = bus.zero ^ bus.funct[0];
               end
            endcase
         end
         S_MEM: begin
            ctrl.mem_read  = op_load;
            ctrl.mem_write = op_store;
         end
         S_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = op_load;
         end
         default: begin
            ctrl = '0;
         end
      endcase
   end

   // Retired-instruction count saturates at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (retire && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State and retire counter registers; reset drops every strobe at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.pc_write    = ctrl.pc_write;
   assign bus.ir_write    = ctrl.ir_write;
   assign bus.reg_write   = ctrl.reg_write;
   assign bus.mem_read    = ctrl.mem_read;
   assign bus.mem_write   = ctrl.mem_write;
   assign bus.mem_to_reg  = ctrl.mem_to_reg;
   assign bus.alu_src1    = ctrl.alu_src1;
   assign bus.alu_src2    = ctrl.alu_src2;
   assign bus.alu_op      = ctrl.alu_op;
   assign bus.jump        = ctrl.jump;
   assign bus.state       = state_q;
   assign bus.halted      = (state_q == S_HALT);
   assign bus.error       = (state_q == S_ERROR);
   assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Self-checking bench for the multicycle control sequencer.
// Instructions are described by class and wait counts, and the bench derives the
// per-cycle expected strobe set and the retire count from those descriptions.
// A second instance with a 4-bit counter, looping on jumps, exercises saturation.
module tb_unidade_controle_multiciclo;

   localparam int TIMEOUT = 15;

   // Expected/observed vector layout:
   // [16]pc_write [15]ir_write [14]reg_write [13]mem_read [12]mem_write
   // [11]mem_to_reg [10]alu_src1 [9:8]alu_src2 [7:6]alu_op [5]jump
   // [4]halted [3]error [2:0]state
   localparam logic [16:0] M_FULL   = 17'h1FFFF;
   localparam logic [16:0] M_NO_M2R = 17'h1F7FF;  // mem_to_reg only matters in WB
   localparam logic [16:0] M_MEM    = 17'h1F03F;  // ALU selects and mem_to_reg free in MEM
   localparam logic [16:0] M_WB     = 17'h1F83F;  // ALU selects free in WB

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] exp_cnt = '0;

   unidade_controle_multiciclo_if #(.CNT_W(16)) u_if ();
   unidade_controle_multiciclo_if #(.CNT_W(4))  u_if_s ();

   unidade_controle_multiciclo #(.MEM_TIMEOUT(15), .CNT_W(16)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   // Small instance that runs jumps back to back so its counter saturates.
   assign u_if_s.opcode    = 2'b11;
   assign u_if_s.funct     = 3'b010;
   assign u_if_s.zero      = 1'b0;
   assign u_if_s.mem_ready = 1'b1;

   unidade_controle_multiciclo #(.MEM_TIMEOUT(15), .CNT_W(4)) u_dut_s (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if_s)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [16:0] pk(input logic pcw, input logic irw, input logic rw,
                                      input logic mr, input logic mw, input logic m2r,
                                      input logic s1, input logic [1:0] s2, input logic [1:0] aop,
                                      input logic j, input logic h, input logic e,
                                      input logic [2:0] st);
      return {pcw, irw, rw, mr, mw, m2r, s1, s2, aop, j, h, e, st};
   endfunction

   function automatic logic [16:0] obs();
      return {u_if.pc_write, u_if.ir_write, u_if.reg_write, u_if.mem_read, u_if.mem_write,
              u_if.mem_to_reg, u_if.alu_src1, u_if.alu_src2, u_if.alu_op, u_if.jump,
              u_if.halted, u_if.error, u_if.state};
   endfunction

   task automatic cmp(input string tag, input logic [16:0] exp, input logic [16:0] mask);
      logic [16:0] o;
      o = obs();
      vectors++;
      assert ((o & mask) === (exp & mask)) else begin
         miscompares++;
         $error("FAIL %s observed=%05h expected=%05h", tag, o & mask, exp & mask);
      end
   endtask

   task automatic cmp_cnt(input string tag);
      vectors++;
      assert (u_if.instr_count === exp_cnt) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, u_if.instr_count, exp_cnt);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic retire();
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      cmp_cnt("instr_count");
   endtask

   // Called just after an edge while rst_n is low; brings the FSM to FETCH.
   task automatic release_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      cmp("idle", pk(0,0,0,0,0,0,0,2'b00,2'b00,0,0,0,3'd0), M_FULL);
      step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      cmp("reset", pk(0,0,0,0,0,0,0,2'b00,2'b00,0,0,0,3'd0), M_FULL);
      exp_cnt = '0;
      cmp_cnt("reset_count");
      release_reset();
   endtask

   task automatic expect_error();
      cmp("error", pk(0,0,0,0,0,0,0,2'b00,2'b00,0,0,1,3'd7), M_NO_M2R);
      cmp_cnt("error_count");
      for (int i = 0; i < 3; i++) begin
         u_if.mem_ready = 1'b1;
         step();
         cmp("error_hold", pk(0,0,0,0,0,0,0,2'b00,2'b00,0,0,1,3'd7), M_NO_M2R);
      end
   endtask

   // Drives `waits` stalled cycles then one completing cycle, unless the wait
   // budget runs out first, in which case timed_out is set and no access completes.
   task automatic wait_phase(input string tag, input logic [16:0] exp_wait,
                             input logic [16:0] exp_done, input logic [16:0] mask,
                             input int waits, output bit timed_out);
      timed_out = 1'b0;
      for (int i = 0; i < waits && i < TIMEOUT; i++) begin
         u_if.mem_ready = 1'b0;
         #1;
         cmp({tag, "_wait"}, exp_wait, mask);
         step();
      end
      if (waits >= TIMEOUT) begin
         timed_out = 1'b1;
      end else begin
         u_if.mem_ready = 1'b1;
         #1;
         cmp({tag, "_done"}, exp_done, mask);
         step();
      end
   endtask

   // Runs one instruction starting at the first FETCH cycle.
   task automatic run_instr(input logic [1:0] op, input logic [2:0] fn, input logic z,
                            input int fw, input int mw);
      bit          to;
      bit          ld;
      bit          st;
      logic        taken;
      logic [16:0] e;
      ld = (op == 2'b01) && (fn == 3'b000);
      st = (op == 2'b01) && (fn == 3'b001);

      // FETCH: the IR still holds old contents, which must not matter here.
      u_if.opcode = 2'($urandom);
      u_if.funct  = 3'($urandom);
      u_if.zero   = 1'($urandom);
      wait_phase("fetch", pk(0,0,0,1,0,0,0,2'b01,2'b00,0,0,0,3'd1),
                 pk(1,1,0,1,0,0,0,2'b01,2'b00,0,0,0,3'd1), M_NO_M2R, fw, to);
      if (to) begin
         expect_error();
         return;
      end

      // DECODE
      u_if.opcode    = op;
      u_if.funct     = fn;
      u_if.zero      = 1'($urandom);
      u_if.mem_ready = 1'($urandom);
      #1;
      if (op == 2'b11 && fn != 3'b111)
         cmp("decode_jump", pk(1,0,0,0,0,0,0,2'b00,2'b00,1,0,0,3'd2), M_NO_M2R);
      else
         cmp("decode", pk(0,0,0,0,0,0,0,2'b00,2'b00,0,0,0,3'd2), M_NO_M2R);
      step();
      if (op == 2'b11) begin
         retire();
         if (fn == 3'b111)
            cmp("halt", pk(0,0,0,0,0,0,0,2'b00,2'b00,0,1,0,3'd6), M_NO_M2R);
         return;
      end

      // EXEC
      u_if.zero      = z;
      u_if.mem_ready = 1'($urandom);
      #1;
      if (op == 2'b00) begin
         e = pk(0,0,0,0,0,0,1,2'b00,2'b10,0,0,0,3'd3);
      end else if (op == 2'b01) begin
         e = (ld || st) ? pk(0,0,0,0,0,0,1,2'b10,2'b00,0,0,0,3'd3)
                        : pk(0,0,0,0,0,0,1,2'b10,2'b11,0,0,0,3'd3);
      end else begin
         taken = (fn[0] == 1'b0) ? z : !z;
         e = pk(taken,0,0,0,0,0,1,2'b00,2'b01,0,0,0,3'd3);
      end
      cmp("exec", e, M_NO_M2R);
      step();
      if (op == 2'b10) begin
         retire();
         return;
      end

      // MEM
      if (ld || st) begin
         wait_phase("mem", pk(0,0,0,ld,st,0,0,2'b00,2'b00,0,0,0,3'd4),
                    pk(0,0,0,ld,st,0,0,2'b00,2'b00,0,0,0,3'd4), M_MEM, mw, to);
         if (to) begin
            expect_error();
            return;
         end
         if (st) begin
            retire();
            return;
         end
      end

      // WB
      u_if.mem_ready = 1'($urandom);
      #1;
      cmp("wb", pk(0,0,1,0,0,ld,0,2'b00,2'b00,0,0,0,3'd5), M_WB);
      step();
      retire();
   endtask

   task automatic random_instrs(input int n);
      logic [1:0] op;
      logic [2:0] fn;
      logic       z;
      int         fw;
      int         mw;
      for (int k = 0; k < n; k++) begin
         op = 2'($urandom_range(0, 3));
         fn = 3'($urandom_range(0, 7));
         if (op == 2'b11 && fn == 3'b111) fn = 3'b000;
         z  = 1'($urandom_range(0, 1));
         fw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 14)) : int'($urandom_range(0, 2));
         mw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 14)) : int'($urandom_range(0, 2));
         run_instr(op, fn, z, fw, mw);
      end
   endtask

   initial begin
      u_if.opcode    = 2'b00;
      u_if.funct     = 3'b000;
      u_if.zero      = 1'b0;
      u_if.mem_ready = 1'b0;
      #2;
      do_reset();

      // Directed instruction classes
      run_instr(2'b00, 3'b010, 1'b0, 0, 0);   // R-type
      run_instr(2'b01, 3'b000, 1'b0, 0, 3);   // load, 3 stalled MEM cycles
      run_instr(2'b01, 3'b001, 1'b0, 1, 0);   // store
      run_instr(2'b10, 3'b000, 1'b1, 0, 0);   // beq taken
      run_instr(2'b10, 3'b000, 1'b0, 0, 0);   // beq not taken
      run_instr(2'b10, 3'b001, 1'b1, 0, 0);   // bne not taken
      run_instr(2'b10, 3'b001, 1'b0, 0, 0);   // bne taken
      run_instr(2'b11, 3'b010, 1'b0, 0, 0);   // jump
      run_instr(2'b01, 3'b011, 1'b0, 2, 0);   // addi
      run_instr(2'b00, 3'b101, 1'b0, 14, 0);  // FETCH completes on the last allowed cycle
      run_instr(2'b01, 3'b000, 1'b0, 2, 14);  // MEM completes on the last allowed cycle

      // Timeouts
      run_instr(2'b00, 3'b000, 1'b0, 15, 0);  // FETCH timeout
      do_reset();
      run_instr(2'b01, 3'b001, 1'b0, 0, 15);  // store timeout in MEM
      do_reset();

      random_instrs(150);

      // Reset asserted mid-store, away from any clock edge
      u_if.opcode    = 2'($urandom);
      u_if.mem_ready = 1'b1;
      step();
      u_if.opcode    = 2'b01;
      u_if.funct     = 3'b001;
      step();
      step();
      u_if.mem_ready = 1'b0;
      #1;
      cmp("mem_store_pre_reset", pk(0,0,0,0,1,0,0,2'b00,2'b00,0,0,0,3'd4), M_MEM);
      #2;
      rst_n = 1'b0;
      #1;
      cmp("mid_access_reset", pk(0,0,0,0,0,0,0,2'b00,2'b00,0,0,0,3'd0), M_FULL);
      exp_cnt = '0;
      cmp_cnt("mid_access_reset_count");
      release_reset();

      random_instrs(20);

      // Halt and stay halted even with memory ready
      run_instr(2'b11, 3'b111, 1'b0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         u_if.mem_ready = 1'b1;
         step();
         cmp("halt_hold", pk(0,0,0,0,0,0,0,2'b00,2'b00,0,1,0,3'd6), M_NO_M2R);
      end
      cmp_cnt("halt_count");

      // 4-bit counter instance has retired far more than 15 jumps by now
      vectors++;
      assert (u_if_s.instr_count === 4'hF) else begin
         miscompares++;
         $error("FAIL saturate observed=%0h expected=f", u_if_s.instr_count);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
